// File: rtl/eth_tx_framer.sv
// Frames a payload byte stream for rgmii_send: zero-pads to MIN_LEN and appends the CRC-32 FCS.
// Latency: one clock from an accepted, pad or FCS byte to data/tx_enable.
// Backpressure: in_ready is low during pad/FCS, and low in idle while phy_active is high.
module eth_tx_framer #(
    parameter int MIN_LEN = 60
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       phy_active,
    output logic [7:0] data,
    output logic       tx_enable,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [1:0] {IDLE, DATA, PAD, FCS} state_t;

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

    state_t      state, state_n;
    logic [31:0] crc, crc_n;
    logic [10:0] len, len_n;
    logic        bad, bad_n;
    logic [1:0]  cnt, cnt_n;
    logic [7:0]  data_n;
    logic        tx_enable_n, frame_done_n, underrun_n;

    logic [10:0] len_inc;
    logic [31:0] fcs_word;

    // Reflected CRC-32, one byte per clock, LSB first
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction

    assign len_inc  = (len == 11'h7FF) ? len : len + 11'd1;
    assign fcs_word = bad ? crc : ~crc;

    always_comb begin
        state_n      = state;
        crc_n        = crc;
        len_n        = len;
        bad_n        = bad;
        cnt_n        = cnt;
        data_n       = 8'h00;
        tx_enable_n  = 1'b0;
        frame_done_n = 1'b0;
        underrun_n   = 1'b0;
        in_ready     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !phy_active;
                if (in_valid && !phy_active) begin
                    crc_n       = crc_next(CRC_INIT, in_data);
                    len_n       = 11'd1;
                    data_n      = in_data;
                    tx_enable_n = 1'b1;
                    cnt_n       = 2'd0;
                    if (in_last) state_n = (11'd1 < MIN_LEN_W) ? PAD : FCS;
                    else         state_n = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    crc_n       = crc_next(crc, in_data);
                    len_n       = len_inc;
                    data_n      = in_data;
                    tx_enable_n = 1'b1;
                    if (in_last) state_n = (len_inc < MIN_LEN_W) ? PAD : FCS;
                end else begin
                    // Upstream gap: the first raw FCS byte goes out this cycle so tx_enable has no bubble
                    bad_n       = 1'b1;
                    underrun_n  = 1'b1;
                    data_n      = crc[7:0];
                    tx_enable_n = 1'b1;
                    cnt_n       = 2'd1;
                    state_n     = FCS;
                end
            end
            PAD: begin
                crc_n       = crc_next(crc, 8'h00);
                len_n       = len_inc;
                tx_enable_n = 1'b1;
                if (len_inc == MIN_LEN_W) state_n = FCS;
            end
            FCS: begin
                data_n      = fcs_word[{cnt, 3'b000} +: 8];
                tx_enable_n = 1'b1;
                cnt_n       = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_n      = IDLE;
                    bad_n        = 1'b0;
                    frame_done_n = 1'b1;
                    crc_n        = CRC_INIT;
                    len_n        = 11'd0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            crc        <= CRC_INIT;
            len        <= 11'd0;
            bad        <= 1'b0;
            cnt        <= 2'd0;
            data       <= 8'h00;
            tx_enable  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            crc        <= crc_n;
            len        <= len_n;
            bad        <= bad_n;
            cnt        <= cnt_n;
            data       <= data_n;
            tx_enable  <= tx_enable_n;
            frame_done <= frame_done_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed-sequence bench for eth_tx_framer with random payloads and a table-driven CRC reference.
module tb_eth_tx_framer;

    localparam int MIN_LEN = 60;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       phy_active = 1'b0;
    logic [7:0] data;
    logic       tx_enable;
    logic       frame_done;
    logic       underrun;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int gap = 0;

    logic [31:0] crc_tbl [256];
    logic [7:0]  payload [256];
    logic [7:0]  exp_q [$];

    // Output capture: flat byte log plus per-frame bookkeeping
    logic [7:0] byte_q [$];
    int f_start [$];
    int f_len [$];
    int f_done [$];
    int f_under [$];
    int f_first [$];
    bit in_frame = 1'b0;
    int cur_start = 0, cur_first = 0, cur_done = -1, cur_under = 0;
    int total_under = 0;
    bit prev_phy = 1'b0;
    int fall_cyc = -1;

    always #5 clock = ~clock;

    eth_tx_framer #(.MIN_LEN(MIN_LEN)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .phy_active (phy_active),
        .data       (data),
        .tx_enable  (tx_enable),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    // rgmii_send activity: busy while sending, then 8-byte purge and 13-byte gap
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tx_enable) begin
            phy_active <= 1'b1;
            gap        <= 21;
        end else if (gap != 0) begin
            gap <= gap - 1;
            if (gap == 1) phy_active <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (underrun) total_under++;
        if (tx_enable) begin
            if (!in_frame) begin
                in_frame  = 1'b1;
                cur_start = byte_q.size();
                cur_first = cyc;
                cur_done  = -1;
                cur_under = 0;
            end
            if (frame_done) cur_done = byte_q.size() - cur_start;
            if (underrun) cur_under++;
            byte_q.push_back(data);
        end else if (in_frame) begin
            in_frame = 1'b0;
            f_start.push_back(cur_start);
            f_len.push_back(byte_q.size() - cur_start);
            f_done.push_back(cur_done);
            f_under.push_back(cur_under);
            f_first.push_back(cur_first);
        end
        if (prev_phy && !phy_active) fall_cyc = cyc;
        prev_phy = phy_active;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_upd(input logic [31:0] c, input logic [7:0] b);
        return (c >> 8) ^ crc_tbl[c[7:0] ^ b];
    endfunction

    // Expected wire image: payload, zero pad (good frames only), FCS LSB first
    task automatic build_exp(input int base, input int n, input bit bad);
        logic [31:0] c;
        logic [31:0] fcs;
        c = 32'hFFFF_FFFF;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(payload[base + i]);
            c = ref_upd(c, payload[base + i]);
        end
        if (!bad) begin
            while (exp_q.size() < MIN_LEN) begin
                exp_q.push_back(8'h00);
                c = ref_upd(c, 8'h00);
            end
        end
        fcs = bad ? c : ~c;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs >> (8 * i)));
    endtask

    task automatic send_frame(input int base, input int n, input int stop_after, output int acc);
        int i;
        int waited;
        i = 0;
        waited = 0;
        acc = -1;
        while (i < n) begin
            @(negedge clock);
            if (i == stop_after) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = payload[base + i];
            in_last  = (i == n - 1);
            if (i == 0) chk("rdy_gate", 32'(in_ready), 32'(!phy_active));
            else        chk("rdy_data", 32'(in_ready), 32'd1);
            if (in_ready) begin
                if (i == 0) acc = cyc;
                i++;
            end else begin
                waited++;
                if (waited > 3000) begin
                    chk("accept_wait", waited, 3000);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_frame(input int k, input bit chk_rdy);
        int t;
        t = 0;
        while (f_len.size() <= k && t < 3000) begin
            @(negedge clock);
            if (chk_rdy) chk("rdy_after_last", 32'(in_ready), 32'd0);
            t++;
        end
        if (f_len.size() <= k) chk("frame_timeout", f_len.size(), k + 1);
    endtask

    task automatic wait_idle(input bit chk_rdy);
        int t;
        t = 0;
        while (phy_active && t < 300) begin
            if (chk_rdy) chk("rdy_while_active", 32'(in_ready), 32'd0);
            @(negedge clock);
            t++;
        end
        chk("phy_fall", 32'(phy_active), 32'd0);
    endtask

    task automatic check_frame(input int k, input int base, input int n, input bit bad, input int acc);
        logic [31:0] r;
        int len;
        wait_frame(k, 1'b0);
        if (f_len.size() <= k) return;
        build_exp(base, n, bad);
        len = f_len[k];
        chk($sformatf("f%0d_len", k), len, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < len; i++)
            chk($sformatf("f%0d_byte%0d", k, i), 32'(byte_q[f_start[k] + i]), 32'(exp_q[i]));
        chk($sformatf("f%0d_done_idx", k), f_done[k], exp_q.size() - 1);
        chk($sformatf("f%0d_underrun", k), f_under[k], 32'(bad));
        chk($sformatf("f%0d_latency", k), f_first[k], acc + 1);
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) r = ref_upd(r, byte_q[f_start[k] + i]);
        if (bad) chk($sformatf("f%0d_resid_bad", k), 32'(r != 32'hDEBB_20E3), 32'd1);
        else     chk($sformatf("f%0d_resid", k), r, 32'hDEBB_20E3);
    endtask

    initial begin
        int acc;
        int acc_a;
        int u0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = 32'(i);
            for (int j = 0; j < 8; j++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
            crc_tbl[i] = v;
            payload[i] = 8'($urandom);
        end

        #1;
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Exactly MIN_LEN bytes: no pad
        send_frame(0, 60, -1, acc);
        check_frame(0, 0, 60, 1'b0, acc);
        wait_idle(1'b0);

        // 42-byte ARP-sized frame: 18 pad bytes, in_ready low until the gap ends
        send_frame(60, 42, -1, acc);
        wait_frame(1, 1'b1);
        check_frame(1, 60, 42, 1'b0, acc);
        wait_idle(1'b1);
        chk("rdy_after_gap", 32'(in_ready), 32'd1);

        // Single byte with in_last on the first byte
        send_frame(102, 1, -1, acc);
        check_frame(2, 102, 1, 1'b0, acc);
        wait_idle(1'b0);

        // Underrun after 20 bytes
        u0 = total_under;
        send_frame(110, 40, 20, acc);
        check_frame(3, 110, 20, 1'b1, acc);
        chk("underrun_pulses", total_under - u0, 1);
        wait_idle(1'b0);

        // Back-to-back: second frame offered while the first is still padding
        send_frame(130, 45, -1, acc);
        acc_a = acc;
        send_frame(175, 50, -1, acc);
        chk("b2b_accept_at_fall", acc, fall_cyc);
        check_frame(4, 130, 45, 1'b0, acc_a);
        check_frame(5, 175, 50, 1'b0, acc);
        wait_idle(1'b0);

        // Reset at byte 30, then a clean frame
        for (int i = 0; i < 128; i++) payload[i] = 8'($urandom);
        send_frame(0, 60, 30, acc);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_tx_enable", 32'(tx_enable), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        @(negedge clock);
        chk("midrst_in_ready", 32'(in_ready), 32'(!phy_active));
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        wait_frame(6, 1'b0);
        if (f_len.size() > 6) begin
            chk("midrst_len", f_len[6], 30);
            chk("midrst_no_done", f_done[6], -1);
        end
        wait_idle(1'b1);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        send_frame(60, 60, -1, acc);
        check_frame(7, 60, 60, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Transmit framing stage that feeds `rgmii_send`. It accepts the Ethernet frame payload (destination MAC through last payload byte, no preamble) as a byte stream with a ready/valid handshake. It pads short frames with zeros to the minimum length and appends the IEEE 802.3 CRC-32 FCS. It drives the `data`/`tx_enable` pair of `rgmii_send` as a gap-free byte stream. The block does not start a new frame while `rgmii_send` reports `active`, so the preamble purge and the inter-frame gap always complete first.

## Interface
- `MIN_LEN`, 60: minimum frame length before FCS, in bytes; shorter frames are zero-padded up to it.
- `clock`  in  1  byte clock, the same clock as `rgmii_send`.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_data`  in  8  frame byte from the upstream builder.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  qualifies the last byte of the frame.
- `in_ready`  out  1  block accepts a byte this cycle (combinational).
- `phy_active`  in  1  `active` output of `rgmii_send`.
- `data`  out  8  byte to `rgmii_send`.
- `tx_enable`  out  1  byte valid to `rgmii_send`; held high for the whole frame including FCS.
- `frame_done`  out  1  one-cycle pulse when the last FCS byte is presented.
- `underrun`  out  1  one-cycle pulse when a frame is aborted because of an input gap.

## Operation
- State machine states: IDLE, DATA, PAD, FCS.
- Byte accept: a byte is accepted when `in_valid & in_ready`.
- `in_ready`:
  - IDLE: `!phy_active`.
  - DATA: 1.
  - PAD and FCS: 0.
- IDLE → DATA: on an accepted byte. CRC is initialised to 0xFFFFFFFF, then updated with that byte, and `len` is set to 1.
  - If `in_last` is set on that first byte, the next state follows the DATA last-byte rule below.
- DATA, byte accepted: CRC is updated, `len` increments.
  - If `in_last`: go to PAD when `len+1 < MIN_LEN`, else go to FCS.
- DATA, `in_valid` low (underrun):
  - Go to FCS with the `bad` flag set and pulse `underrun`.
  - The FCS is then sent as the raw CRC register instead of its complement, so the receiver discards the frame.
  - No padding is added.
- PAD: emit 0x00 each cycle, update CRC and `len`. Go to FCS when `len+1 == MIN_LEN`.
- FCS: emit `~crc` (or `crc` if `bad`) LSB byte first, bits [7:0] … [31:24], over 4 cycles.
  - After the 4th byte: go to IDLE, clear `bad`, pulse `frame_done`.
- CRC: reflected polynomial 0xEDB88320, processing 8 bits per clock, LSB of each byte first.
- `len`: 11 bits, saturating at 2047. It is only compared against `MIN_LEN`. There is no maximum-length check; that belongs upstream.
- IDLE with `phy_active` high: wait. Upstream sees `in_ready` low.

## Timing
- All outputs are registered except `in_ready`.
- Latency: an accepted, pad or FCS byte appears on `data`, with `tx_enable` high, one clock later.
- `tx_enable` is contiguous from the first byte to the 4th FCS byte. There are no bubbles, as `rgmii_send` requires.
- The frame-start gate is safe at the end of a frame:
  - The cycle after the last FCS byte, `tx_enable` is still high and `phy_active` is high.
  - `phy_active` then stays high through the 8-byte purge and 13-byte gap.
  - A new frame therefore cannot start until the gap ends.
- Reset values:
  - `data` = 0x00, `tx_enable` = 0, `frame_done` = 0, `underrun` = 0.
  - State = IDLE, CRC = 0xFFFFFFFF, `len` = 0, `bad` = 0.
- Reset mid-frame: `tx_enable` drops immediately (asynchronously). `rgmii_send` then purges and gaps normally. No FCS is sent.
- `in_last` with `in_valid` low is ignored.
- `in_last` on the byte that reaches exactly `MIN_LEN`: go directly to FCS, with no pad.

## Test plan
- 60-byte frame, continuous `in_valid` → 64 contiguous `tx_enable` cycles, starting 1 clock after the first accept.
  - The last 4 bytes equal `~CRC32` of the 60 bytes, LSB first.
  - Running CRC over all 64 bytes leaves register residue 0xDEBB20E3.
  - `frame_done` pulses on byte 64.
- 42-byte ARP frame → 18 bytes of 0x00 appended, then FCS; 64 bytes total.
  - `in_ready` is low from the cycle after `in_last` until the next frame.
- 1-byte frame with `in_last` on the first byte → 59 pad bytes plus 4 FCS bytes; `tx_enable` high for 64 cycles.
- Underrun: `in_valid` drops after byte 20 → 4 FCS bytes equal the raw (non-complemented) CRC, and `underrun` pulses once.
  - Frame length is 24 bytes; the residue check fails.
- Back-to-back: second frame offered during the first → `in_ready` stays low while `phy_active` is high.
  - The first accept of the second frame occurs the cycle `phy_active` falls.
- `reset_n` asserted at byte 30 → `tx_enable` is 0 immediately.
  - After release: state IDLE, `in_ready` follows `!phy_active`, and the next frame's FCS is correct.
